// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_ctrl
// Purpose  : Instruction-fetch controller between the PC register and decode.
//            Issues one request at a time to a variable-latency instruction
//            memory. Presents the fetched word to decode with a valid/ready
//            handshake. Produces the PC register enable so the PC moves only
//            on consumption or redirect. Flags misaligned fetches and memory
//            timeouts.
// Ports    : clk, rst_n (sync, active-low)
//            pc_in, flush            - PC and redirect from the PC stage
//            pc_advance              - PC register enable
//            imem_req/addr/gnt       - request channel
//            imem_rvalid/rdata       - response channel
//            instr/instr_pc/instr_valid/instr_fault, dec_ready - decode side
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl #(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  input  logic        flush,
  output logic        pc_advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic [1:0]  instr_fault,
  input  logic        dec_ready
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] FAULT_OK    = 2'b00;
  localparam logic [1:0] FAULT_ALIGN = 2'b01;
  localparam logic [1:0] FAULT_TMO   = 2'b10;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t         state, state_d;
  logic           orphan, orphan_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic [31:0]    req_pc, req_pc_d;
  logic [31:0]    instr_d, instr_pc_d;
  logic [1:0]     fault_d;
  logic           valid_d;
  logic           misaligned;

  assign misaligned = (pc_in[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_BOOT;
      orphan      <= 1'b0;
      cnt         <= '0;
      req_pc      <= '0;
      instr       <= NOP_INSTR;
      instr_pc    <= '0;
      instr_fault <= FAULT_OK;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_d;
      orphan      <= orphan_d;
      cnt         <= cnt_d;
      req_pc      <= req_pc_d;
      instr       <= instr_d;
      instr_pc    <= instr_pc_d;
      instr_fault <= fault_d;
      instr_valid <= valid_d;
    end
  end

  always_comb begin
    state_d    = state;
    orphan_d   = orphan;
    cnt_d      = cnt;
    req_pc_d   = req_pc;
    instr_d    = instr;
    instr_pc_d = instr_pc;
    fault_d    = instr_fault;
    imem_req   = 1'b0;
    imem_addr  = pc_in;

    pc_advance = (state == S_BOOT) | ((state == S_HOLD) & dec_ready) | flush;

    // A response arriving outside WAIT can only belong to an abandoned
    // request; it is dropped and releases the orphan lock.
    if ((state != S_WAIT) && imem_rvalid) begin
      orphan_d = 1'b0;
    end

    case (state)
      S_BOOT: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        if (misaligned) begin
          if (!flush) begin
            instr_d    = NOP_INSTR;
            instr_pc_d = pc_in;
            fault_d    = FAULT_ALIGN;
            state_d    = S_HOLD;
          end
        end else if (!orphan) begin
          imem_req = 1'b1;
          if (imem_gnt) begin
            req_pc_d = pc_in;
            cnt_d    = '0;
            // Granted in the same cycle as a redirect: the response will
            // arrive later and must be discarded.
            if (flush) begin
              orphan_d = 1'b1;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
      end

      S_WAIT: begin
        cnt_d = cnt + 1'b1;
        if (flush) begin
          state_d = S_REQ;
          // Data arriving with the flush is simply dropped; otherwise the
          // pending response becomes stale.
          if (!imem_rvalid) begin
            orphan_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          instr_d    = imem_rdata;
          instr_pc_d = req_pc;
          fault_d    = FAULT_OK;
          state_d    = S_HOLD;
        end else if (cnt == CNT_LAST) begin
          instr_d    = NOP_INSTR;
          instr_pc_d = req_pc;
          fault_d    = FAULT_TMO;
          orphan_d   = 1'b1;
          state_d    = S_HOLD;
        end
      end

      S_HOLD: begin
        if (flush || dec_ready) begin
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase

    valid_d = (state_d == S_HOLD);
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_ctrl
// Purpose  : Directed self-checking bench for imem_fetch_ctrl. A small PC
//            register model follows pc_advance (reset value -4, +4 per step,
//            redirect target on flush); memory handshakes are driven directly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

  localparam int unsigned TIMEOUT   = 16;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        flush;
  logic        pc_advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic [1:0]  instr_fault;
  logic        dec_ready;

  logic [31:0] target;
  int          n_assert;
  int          n_fail;

  imem_fetch_ctrl #(
    .TIMEOUT   (TIMEOUT),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_in       (pc_in),
    .flush       (flush),
    .pc_advance  (pc_advance),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_fault (instr_fault),
    .dec_ready   (dec_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register model driven by the controller's enable
  always @(posedge clk) begin
    if (!rst_n)          pc_in <= 32'hFFFF_FFFC;
    else if (pc_advance) pc_in <= flush ? target : pc_in + 32'd4;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    dec_ready   = 1'b0;
    target      = 32'h0;

    // ---- reset values
    step(); step();
    settle();
    chk("rst_instr",  instr,       NOP_INSTR);
    chk("rst_ipc",    instr_pc,    32'h0);
    chk("rst_valid",  {31'b0, instr_valid}, 32'h0);
    chk("rst_fault",  {30'b0, instr_fault}, 32'h0);
    chk("rst_req",    {31'b0, imem_req},    32'h0);

    // ---- cycle 0: BOOT
    rst_n = 1'b1;
    settle();
    chk("boot_adv",   {31'b0, pc_advance},  32'h1);
    step();
    // ---- cycle 1: REQ at 0, grant immediately
    settle();
    chk("c1_req",     {31'b0, imem_req},    32'h1);
    chk("c1_addr",    imem_addr,   32'h0);
    imem_gnt = 1'b1;
    step();
    // ---- cycle 2: WAIT, data returns
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    settle();
    chk("c2_req",     {31'b0, imem_req},    32'h0);
    chk("c2_adv",     {31'b0, pc_advance},  32'h0);
    step();
    // ---- cycle 3: HOLD
    imem_rvalid = 1'b0;
    settle();
    chk("c3_instr",   instr,       32'h0050_0093);
    chk("c3_ipc",     instr_pc,    32'h0);
    chk("c3_valid",   {31'b0, instr_valid}, 32'h1);
    chk("c3_fault",   {30'b0, instr_fault}, 32'h0);

    // ---- decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'b0, instr_valid}, 32'h1);
      chk("stall_instr", instr,              32'h0050_0093);
      chk("stall_adv",   {31'b0, pc_advance}, 32'h0);
      chk("stall_req",   {31'b0, imem_req},   32'h0);
      step();
      settle();
    end
    dec_ready = 1'b1;
    settle();
    chk("take_adv",   {31'b0, pc_advance},  32'h1);
    step();
    dec_ready = 1'b0;
    settle();
    chk("pc4_valid",  {31'b0, instr_valid}, 32'h0);
    chk("pc4_req",    {31'b0, imem_req},    32'h1);
    chk("pc4_addr",   imem_addr,   32'h4);

    // ---- redirect to a misaligned PC (no grant: request withdrawn)
    flush  = 1'b1;
    target = 32'h0000_0006;
    settle();
    chk("fl6_adv",    {31'b0, pc_advance},  32'h1);
    step();
    flush = 1'b0;
    settle();
    chk("mis_req",    {31'b0, imem_req},    32'h0);
    step();
    settle();
    chk("mis_valid",  {31'b0, instr_valid}, 32'h1);
    chk("mis_fault",  {30'b0, instr_fault}, 32'h1);
    chk("mis_instr",  instr,       32'h0000_0013);
    chk("mis_ipc",    instr_pc,    32'h6);

    // ---- redirect from HOLD to 8, then timeout
    flush  = 1'b1;
    target = 32'h0000_0008;
    step();
    flush = 1'b0;
    settle();
    chk("pc8_valid",  {31'b0, instr_valid}, 32'h0);
    chk("pc8_req",    {31'b0, imem_req},    32'h1);
    chk("pc8_addr",   imem_addr,   32'h8);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      settle();
      chk("tmo_wait_valid", {31'b0, instr_valid}, 32'h0);
      step();
    end
    settle();
    chk("tmo_valid",  {31'b0, instr_valid}, 32'h1);
    chk("tmo_fault",  {30'b0, instr_fault}, 32'h2);
    chk("tmo_instr",  instr,       NOP_INSTR);
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    // REQ at 12 but locked until the late response drains
    settle();
    chk("orph_req1",  {31'b0, imem_req},    32'h0);
    step();
    settle();
    chk("orph_req2",  {31'b0, imem_req},    32'h0);
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h7777_7777;
    settle();
    chk("orph_req3",  {31'b0, imem_req},    32'h0);
    step();
    imem_rvalid = 1'b0;
    settle();
    chk("late_valid", {31'b0, instr_valid}, 32'h0);
    chk("after_req",  {31'b0, imem_req},    32'h1);
    chk("after_addr", imem_addr,   32'hC);

    // ---- flush two cycles into WAIT
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    step();
    step();
    flush  = 1'b1;
    target = 32'h0000_0040;
    settle();
    chk("wfl_adv",    {31'b0, pc_advance},  32'h1);
    step();
    flush = 1'b0;
    settle();
    chk("wfl_req1",   {31'b0, imem_req},    32'h0);
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    settle();
    chk("wfl_req2",   {31'b0, imem_req},    32'h0);
    step();
    imem_rvalid = 1'b0;
    settle();
    chk("wfl_valid",  {31'b0, instr_valid}, 32'h0);
    chk("wfl_req3",   {31'b0, imem_req},    32'h1);
    chk("wfl_addr",   imem_addr,   32'h40);
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h00A0_0113;
    step();
    imem_rvalid = 1'b0;
    settle();
    chk("new_instr",  instr,       32'h00A0_0113);
    chk("new_ipc",    instr_pc,    32'h40);
    chk("new_fault",  {30'b0, instr_fault}, 32'h0);

    // ---- rvalid in the last allowed WAIT cycle wins over timeout
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    settle();
    chk("pc44_addr",  imem_addr,   32'h44);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    step();
    imem_rvalid = 1'b0;
    settle();
    chk("edge_valid", {31'b0, instr_valid}, 32'h1);
    chk("edge_fault", {30'b0, instr_fault}, 32'h0);
    chk("edge_instr", instr,       32'h1234_5678);
    chk("edge_ipc",   instr_pc,    32'h44);

    // ---- reset in the middle of WAIT
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    imem_gnt  = 1'b1;
    step();
    imem_gnt = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    settle();
    chk("mrst_instr", instr,       NOP_INSTR);
    chk("mrst_ipc",   instr_pc,    32'h0);
    chk("mrst_valid", {31'b0, instr_valid}, 32'h0);
    chk("mrst_fault", {30'b0, instr_fault}, 32'h0);
    chk("mrst_req",   {31'b0, imem_req},    32'h0);
    rst_n = 1'b1;
    settle();
    chk("mrst_boot",  {31'b0, pc_advance},  32'h1);
    step();
    settle();
    chk("mrst_req1",  {31'b0, imem_req},    32'h1);
    chk("mrst_addr",  imem_addr,   32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch controller sitting directly downstream of the PC register in the single-cycle RISC-V core. Reads the current PC, issues one request at a time to a variable-latency instruction memory, and presents the fetched word to decode with a valid/ready handshake. It produces `pc_advance`, which gates every PC register update, so the PC moves only when an instruction has been consumed or a redirect occurs. It also flags misaligned fetches and memory timeouts.

## Interface
- `TIMEOUT`, default 16: WAIT cycles before a fetch is abandoned as a bus fault. Minimum 2.
- `NOP_INSTR`, default 32'h0000_0013: word presented on any faulted fetch.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `pc_in` in 32: current PC from the PC register.
- `flush` in 1: redirect; the PC loads a branch/jump target this cycle.
- `pc_advance` out 1: PC register enable.
- `imem_req` out 1: request valid.
- `imem_addr` out 32: request address.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: read data valid.
- `imem_rdata` in 32: read data.
- `instr` out 32: fetched instruction, registered.
- `instr_pc` out 32: address of `instr`, registered.
- `instr_valid` out 1: `instr` available to decode.
- `instr_fault` out 2: 00 ok, 01 misaligned, 10 timeout; valid with `instr_valid`.
- `dec_ready` in 1: decode accepts `instr` this cycle.

## Operation
- States:
  - BOOT: after reset.
  - REQ: issue request.
  - WAIT: await data.
  - HOLD: instruction presented.
- Reset values:
  - State is BOOT, the orphan flag is clear, and the timeout counter is 0.
  - `instr` is `NOP_INSTR`, `instr_pc` is 0, and `instr_valid`, `instr_fault` and `imem_req` are 0.
- BOOT: asserts `pc_advance` for exactly one cycle, which steps the PC out of its reset value of -4 to 0. Then goes to REQ.
- REQ, when `pc_in[1:0]` is not 0:
  - No request is issued.
  - Load `instr` = `NOP_INSTR`, `instr_pc` = `pc_in`, `instr_fault` = 01.
  - Go to HOLD.
- REQ, when the orphan flag is set: `imem_req` = 0; stay in REQ.
- REQ, otherwise:
  - Drive `imem_req` = 1 and `imem_addr` = `pc_in`.
  - On `imem_gnt`, latch `pc_in` as the request PC, clear the counter and go to WAIT.
- WAIT:
  - The counter increments every cycle.
  - On `imem_rvalid`, load `instr` = `imem_rdata`, `instr_pc` = the request PC, `instr_fault` = 00, and go to HOLD.
  - When the counter reaches `TIMEOUT` - 1 without `imem_rvalid`:
    - Load `NOP_INSTR` with fault 10 and go to HOLD.
    - Set the orphan flag.
- HOLD:
  - `instr_valid` = 1.
  - On `dec_ready`, assert `pc_advance` and go to REQ; `instr_valid` drops the next cycle.
- `pc_advance` = (state == BOOT) | (state == HOLD & `dec_ready`) | `flush`.
- `flush`, in any state other than BOOT:
  - Next state is REQ and `instr_valid` goes to 0.
  - In WAIT, set the orphan flag so the stale response is discarded.
  - In REQ without grant, the request is withdrawn.
  - In REQ with grant the same cycle, that granted request becomes orphaned.
- Orphan flag:
  - Cleared by `imem_rvalid` while the state is not WAIT; that data is discarded.
  - If `imem_rvalid` and `flush` occur together in WAIT, the data is discarded and no orphan is set.
- Outstanding requests never exceed one. The memory must not return rvalid without a prior grant.

## Timing
- `imem_req`/`imem_addr` are combinational from state and `pc_in`. `pc_in` is stable in REQ because `pc_advance` is low there.
- Fetch latency: grant in cycle t, rvalid in cycle t+k (k ≥ 1), `instr_valid` high in cycle t+k+1.
- Best-case throughput, with immediate grant, k = 1 and `dec_ready` held high: one instruction every 3 cycles.
- Cycles after reset release: cycle 0 is BOOT (`pc_advance` = 1), and cycle 1 is REQ with `imem_addr` = 0.
- Reset asserted mid-fetch: returns to BOOT with the orphan flag clear. The memory is reset by the same `rst_n`.
- The timeout count is exact: abandonment happens at the `TIMEOUT`-th WAIT cycle with no rvalid. An rvalid in that same cycle wins and is taken as normal data.

## Test plan
- Reset, then grant immediately and rvalid the next cycle with data 32'h0050_0093, `dec_ready` = 1:
  - Required: `pc_advance` in cycle 0, `imem_addr` = 0 in cycle 1.
  - Required: `instr` = 32'h0050_0093, `instr_pc` = 0, `instr_valid` high in cycle 3.
- Hold `dec_ready` = 0 for 5 cycles in HOLD: `instr_valid` and `instr` stay stable, `pc_advance` stays 0, and no new `imem_req` is issued.
- `pc_in` = 32'h0000_0006 in REQ: no `imem_req`; `instr_valid` next cycle with fault 01, `instr` = 32'h0000_0013, `instr_pc` = 6.
- Grant with no rvalid for 16 cycles (`TIMEOUT` = 16):
  - Required: fault 10 with `NOP_INSTR`.
  - A late rvalid 3 cycles later is dropped, and the next `imem_req` appears only after it.
- `flush` two cycles into WAIT, then rvalid with data 32'hDEAD_BEEF:
  - Required: `pc_advance` = 1 in the flush cycle; 32'hDEAD_BEEF is never presented.
  - Required: a new request for the redirected `pc_in` follows the orphan response.
- Deassert `rst_n` for one cycle while in WAIT: all outputs return to their reset values, then the BOOT sequence repeats.
